enet_nios_lcell_counter: RTL and testbench
==========================================

// Module: enet_nios_lcell_counter
// PURPOSE
//   Parametrised counter-mode logic-cell chain for the enet_nios subsystem.
//   Generalises the single-bit counter-mode lcell into a WIDTH-bit register with a carry chain.
//   Adds up/down counting, synchronous load, wrap or saturate mode, and a registered wrap pulse.
//   Used for Ethernet MAC timers and byte counters in the Nios peripheral fabric.
// PARAMETERS
//   WIDTH     16  counter width in bits (2..32)
//   POWER_UP  0   value of regout after reset (truncated to WIDTH)
//   SATURATE  0   0: wrap at the ends; 1: hold at all-ones (up) or zero (down)
//   STEP      1   increment/decrement magnitude (1..2**(WIDTH-1)); arithmetic is modulo 2**WIDTH
// PORTS
//   clk       in   1      single clock, rising edge
//   reset_n   in   1      synchronous reset, active low
//   ena       in   1      clock enable for load and count
//   sclr      in   1      synchronous clear to zero; ignores ena
//   sload     in   1      synchronous load of sdata; requires ena
//   sdata     in   WIDTH  load value
//   up_dn     in   1      1: count up; 0: count down
//   combout   out  WIDTH  combinational next value (what regout takes if ena=1)
//   regout    out  WIDTH  registered counter value
//   cout      out  1      combinational terminal count (see below)
//   wrap      out  1      registered 1-cycle pulse: the previous edge wrapped
// BEHAVIOUR
//   - Reset (reset_n=0 at an edge): regout=POWER_UP, wrap=0; overrides all other inputs.
//   - Priority at each edge, highest first: reset_n, sclr, sload&ena, count (ena).
//   - sclr: regout<=0, wrap<=0, regardless of ena.
//   - sload & ena: regout<=sdata, wrap<=0.
//   - ena=0 with no sclr: regout holds; wrap<=0.
//   - Count (ena=1, no sclr/sload), up_dn=1: sum = regout+STEP at WIDTH+1 bits.
//     If the sum overflows: SATURATE=0 gives regout<=sum[WIDTH-1:0] and wrap<=1;
//     SATURATE=1 gives regout<=all-ones and wrap<=0.
//   - Count, up_dn=0: diff = regout-STEP. On underflow (regout<STEP):
//     SATURATE=0 gives regout<=diff modulo 2**WIDTH and wrap<=1;
//     SATURATE=1 gives regout<=0 and wrap<=0.
//   - Zero-latency view: combout equals the value regout will take at the next edge given the
//     current sclr/sload/up_dn with ena=1. combout ignores reset_n; it is purely combinational.
//   - cout=1 exactly when a count step would overflow (up) or underflow (down) from the current
//     regout. This holds independent of ena, sclr and sload.
//   - Saturated and holding (e.g. all-ones with up_dn=1): cout stays 1, wrap stays 0,
//     and regout is stable.
//   - Simultaneous sclr and sload: sclr wins. Flipping up_dn mid-count takes effect on the
//     next edge with no dead cycle.
//   - Reset asserted mid-count discards any pending wrap; the first cycle after reset
//     always shows wrap=0.
//   - No internal state beyond regout and wrap; no FSM latency; no X-propagation from sdata
//     unless sload&ena.
// CONFIGURATION
//   LCELL_CASCADE_EN defined: adds input cin (1 bit). Count steps occur only when ena&cin=1;
//     load and clear are unaffected by cin. cout is additionally ANDed with cin, so that
//     cout(n) -> cin(n+1) chains counters into a wider counter with a one-edge update.
//   LCELL_CASCADE_EN undefined: no cin port; counting behaves as if cin=1.
// TESTING
//   1. reset_n=0 for 1 edge, POWER_UP=5 -> regout=5, wrap=0; then ena=1, up_dn=1 for 3 edges
//      -> regout=8.
//   2. WIDTH=4, SATURATE=0, regout=14, STEP=1, up_dn=1 -> cout=1 at 15; next edge regout=0
//      and wrap=1 for exactly one cycle.
//   3. WIDTH=4, SATURATE=1, regout=1, up_dn=0, ena=1 for 4 edges -> 0,0,0,0; cout=1 at 0;
//      wrap never asserts.
//   4. sclr=1, sload=1, sdata=0xA5, ena=0 -> regout=0. Then sload=1, ena=1 -> regout=0xA5.
//      Then ena=0 -> regout holds at 0xA5.
//   5. LCELL_CASCADE_EN, two WIDTH=4 counters chained, ena=1 for 256 edges from 0 -> combined
//      value returns to 0x00; the high counter's wrap pulses once.
//   6. reset_n=0 asserted the same edge a wrap would occur -> regout=POWER_UP, wrap=0;
//      combout still tracks next value.

Source files
------------

// File: rtl/enet_nios_lcell_counter.sv
`default_nettype none
// ============================================================================
// Module      : enet_nios_lcell_counter
// Description : Parametrised counter-mode logic-cell chain for the enet_nios
//               subsystem. WIDTH-bit register with a carry chain, up/down
//               counting, synchronous clear and load, wrap or saturate at the
//               ends, and a registered one-cycle wrap pulse. Used for
//               Ethernet MAC timers and byte counters.
//
// Parameters  : WIDTH    - counter width in bits (2..32)
//               POWER_UP - regout value after reset (truncated to WIDTH)
//               SATURATE - 0: wrap at the ends; 1: hold at all-ones / zero
//               STEP     - increment/decrement magnitude, modulo 2**WIDTH
//
// Ports       : clk      in   1      rising-edge clock
//               reset_n  in   1      synchronous reset, active low
//               cin      in   1      cascade carry-in (LCELL_CASCADE_EN only)
//               ena      in   1      clock enable for load and count
//               sclr     in   1      synchronous clear, ignores ena
//               sload    in   1      synchronous load of sdata, needs ena
//               sdata    in   WIDTH  load value
//               up_dn    in   1      1: count up, 0: count down
//               combout  out  WIDTH  next value regout takes when ena=1
//               regout   out  WIDTH  registered counter value
//               cout     out  1      terminal count (step would over/underflow)
//               wrap     out  1      registered pulse: previous edge wrapped
//
// Config macro: LCELL_CASCADE_EN - adds cin; count steps need ena&cin, and
//               cout is gated with cin so cout(n) -> cin(n+1) builds a wider
//               counter that updates on a single edge. Undefined: no cin
//               port, counting behaves as if cin=1.
//
// Revision    : 1.0 - initial release
// ============================================================================
module enet_nios_lcell_counter #(
  parameter int WIDTH    = 16,
  parameter int POWER_UP = 0,
  parameter int SATURATE = 0,
  parameter int STEP     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef LCELL_CASCADE_EN
  input  logic             cin,
`endif
  input  logic             ena,
  input  logic             sclr,
  input  logic             sload,
  input  logic [WIDTH-1:0] sdata,
  input  logic             up_dn,
  output logic [WIDTH-1:0] combout,
  output logic [WIDTH-1:0] regout,
  output logic             cout,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_power_up = WIDTH'(POWER_UP);
  localparam logic [WIDTH-1:0] c_step     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic             c_saturate = (SATURATE != 0);

  logic [WIDTH-1:0] r_regout;
  logic             r_wrap;

  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_term;
  logic [WIDTH-1:0] w_count_val;
  logic             w_count_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;

`ifdef LCELL_CASCADE_EN
  assign w_cin = cin;
`else
  assign w_cin = 1'b1;
`endif

  // One extra bit on both paths: the top bit of the sum is the carry out,
  // the top bit of the difference is the borrow (regout < STEP).
  assign w_sum  = {1'b0, r_regout} + {1'b0, c_step};
  assign w_diff = {1'b0, r_regout} - {1'b0, c_step};

  // Terminal count depends only on regout and direction, never on the
  // enable or the clear/load controls.
  assign w_term = up_dn ? w_sum[WIDTH] : w_diff[WIDTH];

  always_comb begin
    w_count_val  = up_dn ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
    w_count_wrap = 1'b0;
    if (w_term) begin
      if (c_saturate) begin
        w_count_val = up_dn ? c_all_ones : '0;
      end else begin
        w_count_wrap = 1'b1;
      end
    end
  end

  // Zero-latency view of the next register value assuming ena=1.
  // Reset is deliberately not folded in here.
  always_comb begin
    w_next = r_regout;
    if (sclr) begin
      w_next = '0;
    end else if (sload) begin
      w_next = sdata;
    end else if (w_cin) begin
      w_next = w_count_val;
    end
  end

  // Only a real count step can raise the wrap flag; clear, load and
  // disabled cycles all return it to zero.
  assign w_wrap_next = ena & ~sclr & ~sload & w_cin & w_count_wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_regout <= c_power_up;
      r_wrap   <= 1'b0;
    end else begin
      if (sclr || ena) begin
        r_regout <= w_next;
      end
      r_wrap <= w_wrap_next;
    end
  end

  assign combout = w_next;
  assign regout  = r_regout;
  assign cout    = w_term & w_cin;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_enet_nios_lcell_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_enet_nios_lcell_counter
// Description : Directed self-checking bench for enet_nios_lcell_counter.
//               Instances: a (16-bit, POWER_UP=5), b (4-bit wrapping),
//               c (4-bit saturating), d (8-bit, STEP=3); with
//               LCELL_CASCADE_EN also a two-stage 4-bit cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enet_nios_lcell_counter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- instance a: WIDTH=16, POWER_UP=5 ----------------
  logic        a_ena, a_sclr, a_sload, a_up;
  logic [15:0] a_sdata, a_comb, a_reg;
  logic        a_cout, a_wrap;
  enet_nios_lcell_counter #(.WIDTH(16), .POWER_UP(5), .SATURATE(0), .STEP(1)) u_a (
    .clk(clk), .reset_n(reset_n),
`ifdef LCELL_CASCADE_EN
    .cin(1'b1),
`endif
    .ena(a_ena), .sclr(a_sclr), .sload(a_sload), .sdata(a_sdata), .up_dn(a_up),
    .combout(a_comb), .regout(a_reg), .cout(a_cout), .wrap(a_wrap));

  // ---------------- instance b: WIDTH=4, wrapping ----------------
  logic       b_ena, b_sclr, b_sload, b_up;
  logic [3:0] b_sdata, b_comb, b_reg;
  logic       b_cout, b_wrap;
  enet_nios_lcell_counter #(.WIDTH(4), .POWER_UP(0), .SATURATE(0), .STEP(1)) u_b (
    .clk(clk), .reset_n(reset_n),
`ifdef LCELL_CASCADE_EN
    .cin(1'b1),
`endif
    .ena(b_ena), .sclr(b_sclr), .sload(b_sload), .sdata(b_sdata), .up_dn(b_up),
    .combout(b_comb), .regout(b_reg), .cout(b_cout), .wrap(b_wrap));

  // ---------------- instance c: WIDTH=4, saturating ----------------
  logic       c_ena, c_sclr, c_sload, c_up;
  logic [3:0] c_sdata, c_comb, c_reg;
  logic       c_cout, c_wrap;
  enet_nios_lcell_counter #(.WIDTH(4), .POWER_UP(0), .SATURATE(1), .STEP(1)) u_c (
    .clk(clk), .reset_n(reset_n),
`ifdef LCELL_CASCADE_EN
    .cin(1'b1),
`endif
    .ena(c_ena), .sclr(c_sclr), .sload(c_sload), .sdata(c_sdata), .up_dn(c_up),
    .combout(c_comb), .regout(c_reg), .cout(c_cout), .wrap(c_wrap));

  // ---------------- instance d: WIDTH=8, STEP=3 ----------------
  logic       d_ena, d_sclr, d_sload, d_up;
  logic [7:0] d_sdata, d_comb, d_reg;
  logic       d_cout, d_wrap;
  enet_nios_lcell_counter #(.WIDTH(8), .POWER_UP(0), .SATURATE(0), .STEP(3)) u_d (
    .clk(clk), .reset_n(reset_n),
`ifdef LCELL_CASCADE_EN
    .cin(1'b1),
`endif
    .ena(d_ena), .sclr(d_sclr), .sload(d_sload), .sdata(d_sdata), .up_dn(d_up),
    .combout(d_comb), .regout(d_reg), .cout(d_cout), .wrap(d_wrap));

`ifdef LCELL_CASCADE_EN
  // ---------------- two-stage 4-bit cascade ----------------
  logic       k_ena;
  logic [3:0] lo_comb, lo_reg, hi_comb, hi_reg;
  logic       lo_cout, lo_wrap, hi_cout, hi_wrap;
  enet_nios_lcell_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .reset_n(reset_n), .cin(1'b1),
    .ena(k_ena), .sclr(1'b0), .sload(1'b0), .sdata(4'h0), .up_dn(1'b1),
    .combout(lo_comb), .regout(lo_reg), .cout(lo_cout), .wrap(lo_wrap));
  enet_nios_lcell_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .reset_n(reset_n), .cin(lo_cout),
    .ena(k_ena), .sclr(1'b0), .sload(1'b0), .sdata(4'h0), .up_dn(1'b1),
    .combout(hi_comb), .regout(hi_reg), .cout(hi_cout), .wrap(hi_wrap));
`endif

  initial begin
    reset_n = 1'b0;
    {a_ena, a_sclr, a_sload, a_up} = 4'b0001; a_sdata = '0;
    {b_ena, b_sclr, b_sload, b_up} = 4'b0001; b_sdata = '0;
    {c_ena, c_sclr, c_sload, c_up} = 4'b0001; c_sdata = '0;
    {d_ena, d_sclr, d_sload, d_up} = 4'b0001; d_sdata = '0;
`ifdef LCELL_CASCADE_EN
    k_ena = 1'b0;
`endif

    // Reset state
    tick();
    check("a_reset_regout", 32'(a_reg), 32'd5);
    check("a_reset_wrap", 32'(a_wrap), 32'd0);
    check("b_reset_regout", 32'(b_reg), 32'd0);
    check("a_comb_after_reset", 32'(a_comb), 32'd6);
    check("a_cout_idle", 32'(a_cout), 32'd0);

    // Count up three edges from POWER_UP
    reset_n = 1'b1;
    a_ena = 1'b1;
    repeat (3) tick();
    check("a_count3", 32'(a_reg), 32'd8);
    check("a_count3_wrap", 32'(a_wrap), 32'd0);

    // sclr beats sload, and ignores ena
    a_ena = 1'b0; a_sclr = 1'b1; a_sload = 1'b1; a_sdata = 16'h00A5;
    #1 check("a_comb_sclr", 32'(a_comb), 32'd0);
    tick();
    check("a_sclr_regout", 32'(a_reg), 32'd0);
    a_sclr = 1'b0; a_ena = 1'b1;
    tick();
    check("a_load_regout", 32'(a_reg), 32'h00A5);
    a_sload = 1'b0; a_ena = 1'b0;
    tick(); tick();
    check("a_hold_regout", 32'(a_reg), 32'h00A5);
    check("a_hold_wrap", 32'(a_wrap), 32'd0);

    // Up wrap from all-ones, then pulse clears
    a_ena = 1'b1; a_sload = 1'b1; a_sdata = 16'hFFFF;
    tick();
    a_sload = 1'b0;
    #1;
    check("a_comb_at_max", 32'(a_comb), 32'd0);
    check("a_cout_at_max", 32'(a_cout), 32'd1);
    tick();
    check("a_wrap_regout", 32'(a_reg), 32'd0);
    check("a_wrap_pulse", 32'(a_wrap), 32'd1);
    // Direction change takes effect on the very next edge
    a_up = 1'b0;
    #1 check("a_cout_down0", 32'(a_cout), 32'd1);
    tick();
    check("a_down_wrap_regout", 32'(a_reg), 32'hFFFF);
    check("a_down_wrap_pulse", 32'(a_wrap), 32'd1);
    tick();
    check("a_down_step", 32'(a_reg), 32'hFFFE);
    check("a_wrap_cleared", 32'(a_wrap), 32'd0);

    // Reset on the edge a wrap would occur
    a_up = 1'b1; a_sload = 1'b1; a_sdata = 16'hFFFF;
    tick();
    a_sload = 1'b0;
    reset_n = 1'b0;
    tick();
    check("a_rst_wrap_regout", 32'(a_reg), 32'd5);
    check("a_rst_wrap_wrap", 32'(a_wrap), 32'd0);
    check("a_rst_comb", 32'(a_comb), 32'd6);
    reset_n = 1'b1;

    // 4-bit wrap: 14 -> 15 -> 0 (wrap) -> 1
    b_ena = 1'b1; b_sload = 1'b1; b_sdata = 4'd14;
    tick();
    b_sload = 1'b0;
    check("b_cout_at14", 32'(b_cout), 32'd0);
    tick();
    check("b_regout15", 32'(b_reg), 32'd15);
    check("b_cout_at15", 32'(b_cout), 32'd1);
    tick();
    check("b_regout0", 32'(b_reg), 32'd0);
    check("b_wrap_pulse", 32'(b_wrap), 32'd1);
    tick();
    check("b_regout1", 32'(b_reg), 32'd1);
    check("b_wrap_once", 32'(b_wrap), 32'd0);

    // 4-bit saturate down: 1 -> 0,0,0,0 with no wrap
    c_ena = 1'b1; c_sload = 1'b1; c_sdata = 4'd1;
    tick();
    c_sload = 1'b0; c_up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("c_sat_down_regout", 32'(c_reg), 32'd0);
      check("c_sat_down_wrap", 32'(c_wrap), 32'd0);
    end
    check("c_sat_down_cout", 32'(c_cout), 32'd1);
    // Saturate up at all-ones
    c_sload = 1'b1; c_sdata = 4'd15;
    tick();
    c_sload = 1'b0; c_up = 1'b1;
    tick();
    check("c_sat_up_regout", 32'(c_reg), 32'd15);
    check("c_sat_up_wrap", 32'(c_wrap), 32'd0);
    check("c_sat_up_cout", 32'(c_cout), 32'd1);

    // STEP=3: 1 - 3 = 0xFE (wrap); 0xFE + 3 = 0x01 (wrap); 0xFC + 3 = 0xFF
    d_ena = 1'b1; d_sload = 1'b1; d_sdata = 8'd1;
    tick();
    d_sload = 1'b0; d_up = 1'b0;
    #1;
    check("d_cout_down", 32'(d_cout), 32'd1);
    check("d_comb_down", 32'(d_comb), 32'hFE);
    tick();
    check("d_regout_down", 32'(d_reg), 32'hFE);
    check("d_wrap_down", 32'(d_wrap), 32'd1);
    d_up = 1'b1;
    #1 check("d_comb_up", 32'(d_comb), 32'h01);
    tick();
    check("d_regout_up", 32'(d_reg), 32'h01);
    check("d_wrap_up", 32'(d_wrap), 32'd1);
    d_sload = 1'b1; d_sdata = 8'hFC;
    tick();
    d_sload = 1'b0;
    #1 check("d_cout_nowrap", 32'(d_cout), 32'd0);
    tick();
    check("d_regout_ff", 32'(d_reg), 32'hFF);
    check("d_wrap_none", 32'(d_wrap), 32'd0);

`ifdef LCELL_CASCADE_EN
    begin
      int hi_wraps;
      hi_wraps = 0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      k_ena = 1'b1;
      for (int i = 0; i < 256; i++) begin
        tick();
        if (hi_wrap) hi_wraps++;
        if (i == 15) check("k_after16", 32'({hi_reg, lo_reg}), 32'h10);
      end
      check("k_after256", 32'({hi_reg, lo_reg}), 32'h00);
      check("k_hi_wraps", 32'(hi_wraps), 32'd1);
      k_ena = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
